// File: rtl/axis_packet_buffer.sv
// AXI-Stream packet buffer: store-and-forward (whole-packet commit, drop on overflow)
// or cut-through (beat-level forwarding with back-pressure), selected by STORE_FWD.
module axis_packet_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int MEM_SIZE   = 4096,
    parameter int STORE_FWD  = 1,
    parameter int MAX_PKTS   = 16
) (
    input  logic                          axis_aclk,
    input  logic                          axis_areset,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]       s_axis_tstrb,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]       m_axis_tstrb,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic [ADDR_WIDTH:0]           fill_level,
    output logic [$clog2(MAX_PKTS+1)-1:0] pkt_count,
    output logic                          drop_pkt
);

    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int ENTRY_W = DATA_WIDTH + STRB_W + 1;
    localparam int CNT_W   = $clog2(MAX_PKTS + 1);

    typedef logic [ADDR_WIDTH:0]   lvl_t;
    typedef logic [ADDR_WIDTH-1:0] ptr_t;
    typedef enum logic {ACCEPT, DROP} wr_state_t;

    localparam lvl_t FULL    = lvl_t'(MEM_SIZE);
    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam lvl_t LVL_ONE = lvl_t'(1);

    wr_state_t state, state_next;

    logic [ENTRY_W-1:0] mem [MEM_SIZE];
    ptr_t cur_ptr, com_ptr, rd_ptr;
    lvl_t part_cnt, avail, commit_len;
    logic full, s_xfer, m_xfer, pkt_done;
    logic wr_en, commit, rewind, drop_next;
    logic fetch, out_load;
    logic               vld_p1;
    logic [ENTRY_W-1:0] data_p1;

    assign full     = (fill_level == FULL);
    assign s_xfer   = s_axis_tvalid && s_axis_tready;
    assign m_xfer   = m_axis_tvalid && m_axis_tready;
    assign pkt_done = m_xfer && m_axis_tlast;
    // part_cnt stays 0 in cut-through, so every committed beat counts as one
    assign commit_len = part_cnt + LVL_ONE;

    // Store-and-forward only throttles at a packet boundary, so a started packet always finishes
    always_comb begin
        if (STORE_FWD == 0)
            s_axis_tready = !axis_areset && !full;
        else
            s_axis_tready = !axis_areset &&
                            !(state == ACCEPT && part_cnt == '0 &&
                              pkt_count == CNT_W'(MAX_PKTS));
    end

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        commit     = 1'b0;
        rewind     = 1'b0;
        drop_next  = 1'b0;
        if (STORE_FWD == 0) begin
            wr_en  = s_xfer;
            commit = s_xfer;
        end else begin
            case (state)
                ACCEPT: begin
                    if (s_xfer) begin
                        if (!full) begin
                            wr_en  = 1'b1;
                            commit = s_axis_tlast;
                        end else begin
                            rewind = 1'b1;
                            if (s_axis_tlast) drop_next  = 1'b1;
                            else              state_next = DROP;
                        end
                    end
                end
                DROP: begin
                    if (s_xfer && s_axis_tlast) begin
                        drop_next  = 1'b1;
                        state_next = ACCEPT;
                    end
                end
                default: state_next = ACCEPT;
            endcase
        end
    end

    // Stage p1 fetches committed beats from memory; the output register is the last stage
    assign out_load = vld_p1 && (!m_axis_tvalid || m_axis_tready);
    assign fetch    = (avail != '0) && (!vld_p1 || out_load);

    always_ff @(posedge axis_aclk) begin
        if (wr_en) mem[cur_ptr] <= {s_axis_tdata, s_axis_tstrb, s_axis_tlast};
        if (fetch) data_p1 <= mem[rd_ptr];
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            state         <= ACCEPT;
            cur_ptr       <= '0;
            com_ptr       <= '0;
            rd_ptr        <= '0;
            part_cnt      <= '0;
            avail         <= '0;
            fill_level    <= '0;
            pkt_count     <= '0;
            drop_pkt      <= 1'b0;
            vld_p1        <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tstrb  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            state    <= state_next;
            drop_pkt <= drop_next;
            if (rewind)     cur_ptr <= com_ptr;
            else if (wr_en) cur_ptr <= cur_ptr + PTR_ONE;
            if (commit) com_ptr <= cur_ptr + PTR_ONE;
            if (rewind || commit) part_cnt <= '0;
            else if (wr_en)       part_cnt <= part_cnt + LVL_ONE;
            avail      <= avail + (commit ? commit_len : '0) - lvl_t'(fetch);
            fill_level <= fill_level + lvl_t'(wr_en) - lvl_t'(m_xfer) - (rewind ? part_cnt : '0);
            if (STORE_FWD != 0)
                pkt_count <= pkt_count + CNT_W'(commit) - CNT_W'(pkt_done);
            if (fetch) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                vld_p1 <= 1'b1;
            end else if (out_load) begin
                vld_p1 <= 1'b0;
            end
            if (out_load) begin
                m_axis_tvalid <= 1'b1;
                {m_axis_tdata, m_axis_tstrb, m_axis_tlast} <= data_p1;
            end else if (m_xfer) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_packet_buffer.sv
// Directed bench: a 16-entry store-and-forward buffer (MAX_PKTS=2) and a 16-entry cut-through buffer.
module tb_axis_packet_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sf_rst, sf_tv, sf_tl, sf_tr, sf_mv, sf_ml, sf_mr, sf_drop;
    logic [31:0] sf_td, sf_mtd;
    logic [3:0]  sf_ts, sf_mts;
    logic [4:0]  sf_fill;
    logic [1:0]  sf_pc;

    logic        ct_rst, ct_tv, ct_tl, ct_tr, ct_mv, ct_ml, ct_mr, ct_drop;
    logic [31:0] ct_td, ct_mtd;
    logic [3:0]  ct_ts, ct_mts;
    logic [4:0]  ct_fill;
    logic [4:0]  ct_pc;

    int checks = 0;
    int errors = 0;

    axis_packet_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .MEM_SIZE(16), .STORE_FWD(1), .MAX_PKTS(2)) u_sf (
        .axis_aclk(clk), .axis_areset(sf_rst),
        .s_axis_tdata(sf_td), .s_axis_tstrb(sf_ts), .s_axis_tvalid(sf_tv), .s_axis_tlast(sf_tl),
        .s_axis_tready(sf_tr),
        .m_axis_tdata(sf_mtd), .m_axis_tstrb(sf_mts), .m_axis_tvalid(sf_mv), .m_axis_tlast(sf_ml),
        .m_axis_tready(sf_mr),
        .fill_level(sf_fill), .pkt_count(sf_pc), .drop_pkt(sf_drop)
    );

    axis_packet_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .MEM_SIZE(16), .STORE_FWD(0), .MAX_PKTS(16)) u_ct (
        .axis_aclk(clk), .axis_areset(ct_rst),
        .s_axis_tdata(ct_td), .s_axis_tstrb(ct_ts), .s_axis_tvalid(ct_tv), .s_axis_tlast(ct_tl),
        .s_axis_tready(ct_tr),
        .m_axis_tdata(ct_mtd), .m_axis_tstrb(ct_mts), .m_axis_tvalid(ct_mv), .m_axis_tlast(ct_ml),
        .m_axis_tready(ct_mr),
        .fill_level(ct_fill), .pkt_count(ct_pc), .drop_pkt(ct_drop)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx, iidx, oidx;
        logic acc, outx;

        sf_rst = 1'b1; ct_rst = 1'b1;
        sf_tv = 1'b0; sf_tl = 1'b0; sf_td = '0; sf_ts = 4'hF; sf_mr = 1'b1;
        ct_tv = 1'b0; ct_tl = 1'b0; ct_td = '0; ct_ts = 4'hF; ct_mr = 1'b1;
        tick();
        tick();
        chk("rst_sf_tready", 32'(sf_tr), 32'd0);
        chk("rst_ct_tready", 32'(ct_tr), 32'd0);
        chk("rst_sf_mvalid", 32'(sf_mv), 32'd0);
        chk("rst_sf_fill",   32'(sf_fill), 32'd0);
        chk("rst_sf_pkt",    32'(sf_pc), 32'd0);
        chk("rst_sf_drop",   32'(sf_drop), 32'd0);
        chk("rst_ct_mvalid", 32'(ct_mv), 32'd0);
        sf_rst = 1'b0; ct_rst = 1'b0;
        #1;
        chk("rel_sf_tready", 32'(sf_tr), 32'd1);
        chk("rel_ct_tready", 32'(ct_tr), 32'd1);

        // store-and-forward: nothing leaves before tlast, then two-edge latency
        for (int i = 0; i < 4; i++) begin
            sf_tv = 1'b1; sf_td = 32'hA0 + i; sf_tl = (i == 3);
            tick();
            chk("sf_hold_until_last", 32'(sf_mv), 32'd0);
        end
        sf_tv = 1'b0; sf_tl = 1'b0;
        chk("sf_pkt_after_last", 32'(sf_pc), 32'd1);
        chk("sf_fill_after_last", 32'(sf_fill), 32'd4);
        tick();
        chk("sf_latency_n1", 32'(sf_mv), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) chk("sf_pkt_while_out", 32'(sf_pc), 32'd1);
            chk("sf_out_valid", 32'(sf_mv), 32'd1);
            chk("sf_out_data", sf_mtd, 32'hA0 + i);
            chk("sf_out_last", 32'(sf_ml), 32'(i == 3));
            tick();
        end
        chk("sf_out_done", 32'(sf_mv), 32'd0);
        chk("sf_pkt_end", 32'(sf_pc), 32'd0);
        chk("sf_fill_end", 32'(sf_fill), 32'd0);

        // cut-through: first beat visible after edge N+2 without waiting for tlast
        for (int k = 0; k < 7; k++) begin
            ct_tv = (k < 4); ct_td = 32'hA0 + k; ct_tl = (k == 3);
            tick();
            if (k >= 2 && k <= 5) begin
                chk("ct_out_valid", 32'(ct_mv), 32'd1);
                chk("ct_out_data", ct_mtd, 32'hA0 + k - 2);
                chk("ct_out_last", 32'(ct_ml), 32'(k == 5));
            end else begin
                chk("ct_out_idle", 32'(ct_mv), 32'd0);
            end
        end
        chk("ct_fill_end", 32'(ct_fill), 32'd0);
        chk("ct_pkt_zero", 32'(ct_pc), 32'd0);

        // store-and-forward with downstream stalls on alternate cycles
        for (int i = 0; i < 8; i++) begin
            sf_tv = 1'b1; sf_td = 32'hB0 + i; sf_ts = 4'(i) ^ 4'hA; sf_tl = (i == 7);
            tick();
        end
        sf_tv = 1'b0; sf_tl = 1'b0;
        tick();
        tick();
        idx = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            sf_mr = (c % 2 == 0);
            chk("stall_valid", 32'(sf_mv), 32'd1);
            chk("stall_data", sf_mtd, 32'hB0 + idx);
            chk("stall_strb", 32'(sf_mts), 32'(4'(idx) ^ 4'hA));
            chk("stall_last", 32'(sf_ml), 32'(idx == 7));
            acc = sf_mv && sf_mr;
            tick();
            if (acc) idx++;
        end
        sf_mr = 1'b1;
        chk("stall_all_out", 32'(idx), 32'd8);
        chk("stall_idle", 32'(sf_mv), 32'd0);
        chk("stall_fill", 32'(sf_fill), 32'd0);

        // overflow: second packet hits full on its 7th beat and is dropped whole
        sf_mr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sf_tv = 1'b1; sf_td = 32'hC0 + i; sf_tl = (i == 9);
            tick();
        end
        chk("ovf_fill_p1", 32'(sf_fill), 32'd10);
        chk("ovf_pkt_p1", 32'(sf_pc), 32'd1);
        for (int i = 0; i < 10; i++) begin
            sf_tv = 1'b1; sf_td = 32'hD0 + i; sf_tl = (i == 9);
            chk("ovf_tready", 32'(sf_tr), 32'd1);
            tick();
            chk("ovf_drop_pulse", 32'(sf_drop), 32'(i == 9));
            if (i == 5) chk("ovf_fill_full", 32'(sf_fill), 32'd16);
            if (i == 6) chk("ovf_fill_rewind", 32'(sf_fill), 32'd10);
        end
        sf_tv = 1'b0; sf_tl = 1'b0;
        tick();
        chk("ovf_drop_once", 32'(sf_drop), 32'd0);
        chk("ovf_fill_after", 32'(sf_fill), 32'd10);
        chk("ovf_pkt_after", 32'(sf_pc), 32'd1);
        sf_mr = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("ovf_out_data", sf_mtd, 32'hC0 + k);
            chk("ovf_out_last", 32'(sf_ml), 32'(k == 9));
            tick();
        end
        tick();
        chk("ovf_no_p2", 32'(sf_mv), 32'd0);
        chk("ovf_fill_end", 32'(sf_fill), 32'd0);

        // cut-through back-pressure at 16 beats, then drain of all 20
        ct_mr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ct_tv = 1'b1; ct_td = 32'hE0 + i; ct_tl = 1'b0;
            chk("ct_bp_ready", 32'(ct_tr), 32'd1);
            tick();
        end
        ct_td = 32'hE0 + 16;
        chk("ct_bp_full", 32'(ct_tr), 32'd0);
        chk("ct_bp_fill", 32'(ct_fill), 32'd16);
        tick();
        chk("ct_bp_hold", 32'(ct_tr), 32'd0);
        ct_mr = 1'b1;
        iidx = 16; oidx = 0;
        for (int c = 0; c < 80 && oidx < 20; c++) begin
            ct_tv = (iidx < 20); ct_td = 32'hE0 + iidx; ct_tl = (iidx == 19);
            acc  = ct_tv && ct_tr;
            outx = ct_mv && ct_mr;
            if (outx) begin
                chk("ct_drain_data", ct_mtd, 32'hE0 + oidx);
                chk("ct_drain_last", 32'(ct_ml), 32'(oidx == 19));
                oidx++;
            end
            tick();
            if (acc) iidx++;
        end
        ct_tv = 1'b0; ct_tl = 1'b0;
        chk("ct_drain_count", 32'(oidx), 32'd20);
        chk("ct_drain_fill", 32'(ct_fill), 32'd0);
        chk("ct_no_drop", 32'(ct_drop), 32'd0);

        // packet limit, then asynchronous reset mid-packet
        sf_mr = 1'b0;
        sf_tv = 1'b1; sf_td = 32'hF0; sf_tl = 1'b1;
        tick();
        sf_td = 32'hF1;
        tick();
        chk("lim_ready_low", 32'(sf_tr), 32'd0);
        sf_td = 32'hF2;
        tick();
        tick();
        chk("lim_still_low", 32'(sf_tr), 32'd0);
        chk("lim_pkt", 32'(sf_pc), 32'd2);
        chk("lim_fill", 32'(sf_fill), 32'd2);
        sf_tv = 1'b0; sf_mr = 1'b1;
        tick();
        sf_mr = 1'b0;
        chk("lim_pkt_dec", 32'(sf_pc), 32'd1);
        chk("lim_next_data", sf_mtd, 32'hF1);
        chk("lim_ready_back", 32'(sf_tr), 32'd1);
        sf_tv = 1'b1; sf_td = 32'h60; sf_tl = 1'b0;
        tick();
        sf_td = 32'h61;
        tick();
        chk("mid_fill", 32'(sf_fill), 32'd3);
        #2 sf_rst = 1'b1;
        #1;
        chk("arst_mvalid", 32'(sf_mv), 32'd0);
        chk("arst_fill", 32'(sf_fill), 32'd0);
        chk("arst_pkt", 32'(sf_pc), 32'd0);
        chk("arst_tready", 32'(sf_tr), 32'd0);
        sf_tv = 1'b0;
        tick();
        tick();
        sf_rst = 1'b0;
        sf_mr  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sf_tv = (k < 2); sf_td = 32'h70 + k; sf_tl = (k == 1);
            tick();
            if (k == 3 || k == 4) begin
                chk("post_rst_valid", 32'(sf_mv), 32'd1);
                chk("post_rst_data", sf_mtd, 32'h70 + k - 3);
                chk("post_rst_last", 32'(sf_ml), 32'(k == 4));
            end else begin
                chk("post_rst_idle", 32'(sf_mv), 32'd0);
            end
        end
        chk("post_rst_pkt", 32'(sf_pc), 32'd0);
        chk("post_rst_fill", 32'(sf_fill), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
